rmt_wrapper: RTL and testbench
==============================

RMT_WRAPPER -- requirements
Module: rmt_wrapper

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH, default 32: reserved control-bus width; no ports use it.
REQ-002 Parameter C_S_AXI_ADDR_WIDTH, default 12: reserved; no ports use it.
REQ-003 Parameter C_BASEADDR, default 32'h80000000: reserved; no ports use it.
REQ-004 Parameter C_S_AXIS_DATA_WIDTH, default 512: input stream data width.
REQ-005 Parameter C_S_AXIS_TUSER_WIDTH, default 128: stream tuser width, input and output.
REQ-006 Parameter C_M_AXIS_DATA_WIDTH, default 512: output data width; must equal C_S_AXIS_DATA_WIDTH.
REQ-007 Parameter PHV_ADDR_WIDTH, default 4: log2 of the beat-FIFO depth (16 beats).
REQ-008 Port clk, input, 1: single clock for all logic.
REQ-009 Port aresetn, input, 1: reset, synchronous, active-low.
REQ-010 Ports s_axis_tdata (in, 512), s_axis_tkeep (in, 64), s_axis_tuser (in, 128), s_axis_tvalid (in, 1), s_axis_tlast (in, 1): AXI4-Stream slave.
REQ-011 Port s_axis_tready, output, 1: slave ready.
REQ-012 Ports m_axis_tdata (out, 512), m_axis_tkeep (out, 64), m_axis_tuser (out, 128), m_axis_tvalid (out, 1), m_axis_tlast (out, 1): AXI4-Stream master.
REQ-013 Port m_axis_tready, input, 1: master ready.

Function
REQ-014 Byte lane k is tdata[8k+7:8k]. Every frame is treated as VLAN-tagged; the TPID is not checked.
REQ-015 On the first beat of each packet, the block extracts the following fields:
- VID = {byte14[3:0], byte15}.
- ETYPE = {byte16, byte17}.
- PROTO = byte27.
REQ-016 The first beat is the first accepted beat after reset, or the first accepted beat after an accepted beat with tlast=1.
REQ-017 CLASS is 2 bits:
- 0 when ETYPE != 16'h0800.
- 1 when the packet is IPv4 and PROTO is any value other than 6 or 17.
- 2 when IPv4 and PROTO = 6.
- 3 when IPv4 and PROTO = 17.
REQ-018 m_axis_tuser = {2'b00, CLASS, VID, s_axis_tuser[111:0]}, i.e. [127:126]=0, [125:124]=CLASS, [123:112]=VID.
REQ-019 CLASS and VID are latched from the first beat and applied to every beat of that packet.
REQ-020 tdata, tkeep and tlast pass through unmodified and in order; no beat is dropped, duplicated or reordered.
REQ-021 A beat transfers only when valid and ready are both high, on both ports.
REQ-022 m_axis_tvalid and all m_axis payload outputs stay stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-023 Accepted beats enter a 16-beat FIFO holding {tdata, tkeep, tlast, tuser}.
REQ-024 s_axis_tready = 1 whenever the FIFO is not full, independent of m_axis_tready.
REQ-025 When full and popped in the same cycle, s_axis_tready stays 0 that cycle (no full-bypass).
REQ-026 Latency: a beat accepted at clock edge N, with FIFO empty and m_axis_tready=1, is presented on m_axis with m_axis_tvalid=1 after edge N+2.
REQ-027 Sustained throughput is 1 beat per cycle when m_axis_tready=1.
REQ-028 Simultaneous push and pop at any non-full occupancy leaves the occupancy unchanged.
REQ-029 FIFO pointers wrap modulo 16.
REQ-030 A single-beat packet (tlast on its first beat) is classified from that beat alone.

Reset
REQ-031 While aresetn=0 at a clock edge:
- FIFO is emptied.
- First-beat tracker is set to "expect first beat".
- Latched CLASS and VID are cleared to 0.
- m_axis_tvalid=0 and m_axis_tlast=0.
- m_axis_tdata, m_axis_tkeep and m_axis_tuser are 0.
- s_axis_tready=0.
REQ-032 s_axis_tready rises on the first clock edge after aresetn returns to 1.
REQ-033 Reset asserted mid-packet discards all buffered beats; the next accepted beat is treated as a first beat.

Structure
REQ-034 Shared package rmt_pkg holds:
- Byte offsets 14, 16, 27.
- ETYPE_IPV4 = 16'h0800, PROTO_TCP = 6, PROTO_UDP = 17.
- CLASS encodings.
- tuser field bit positions.
REQ-035 One sub-module, rmt_axis_fifo: parameterized-width, depth 2**PHV_ADDR_WIDTH, registered output.
REQ-036 The parser/classifier logic lives in rmt_wrapper.

Verification
REQ-037 Reset test: pulse aresetn low for 1 cycle -> all outputs 0 during reset; s_axis_tready=1 one edge after release.
REQ-038 Non-IP test: 4-beat packet, tkeep all ones, first beat = {128'hff..ff, 256'b0, 12'h020, 116'b0} -> 4 output beats, identical data and tlast, tuser[125:124]=0 and tuser[123:112]=12'h002 on all beats.
REQ-039 IPv4/UDP test: first beat = {128'hff..ff, 159'b0, 8'h11, 72'b0, 16'h0008, 128'b0}, 3 further beats, 6 idle cycles after the prior packet -> tuser[125:124]=3, VID=0 on all 4 beats; first output beat 2 cycles after its acceptance.
REQ-040 TCP/other test: byte27 = 6, then byte27 = 1, with ETYPE 0x0800 -> CLASS=2, then CLASS=1.
REQ-041 Backpressure test: hold m_axis_tready=0 while sending 20 beats -> exactly 16 accepted, then s_axis_tready=0; release -> all beats emerge in order, payload stable while stalled.
REQ-042 Mid-packet reset test: assert reset after beat 2 of 4, then send a UDP packet -> no stale beats are output; the new packet's first beat is classified CLASS=3.

Source files
------------

// File: rtl/rmt_pkg.sv
// Shared constants, class encodings and the packet classifier used by rmt_wrapper.
package rmt_pkg;

  localparam int unsigned VID_BYTE   = 14;
  localparam int unsigned ETYPE_BYTE = 16;
  localparam int unsigned PROTO_BYTE = 27;

  localparam logic [15:0] ETYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  PROTO_TCP  = 8'd6;
  localparam logic [7:0]  PROTO_UDP  = 8'd17;

  localparam int unsigned VID_WIDTH       = 12;
  localparam int unsigned TUSER_VID_LSB   = 112;
  localparam int unsigned TUSER_CLASS_LSB = 124;
  localparam int unsigned TUSER_PAD_LSB   = 126;

  typedef enum logic [1:0] {
    CLASS_NON_IP   = 2'd0,
    CLASS_IP_OTHER = 2'd1,
    CLASS_TCP      = 2'd2,
    CLASS_UDP      = 2'd3
  } class_e;

  function automatic class_e classify(input logic [15:0] etype, input logic [7:0] proto);
    class_e c;
    if (etype != ETYPE_IPV4) begin
      c = CLASS_NON_IP;
    end else begin
      case (proto)
        PROTO_TCP: c = CLASS_TCP;
        PROTO_UDP: c = CLASS_UDP;
        default:   c = CLASS_IP_OTHER;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/rmt_axis_fifo.sv
// Beat FIFO with a registered output stage; written entries become readable one
// cycle after the write, and the output register counts toward the capacity.
module rmt_axis_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH+1:0] DEPTH_LVL = (ADDR_WIDTH + 2)'(DEPTH);

  logic [WIDTH-1:0]      mem_r [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr_r, wr_vis_r, rd_ptr_r;
  logic [ADDR_WIDTH:0]   wr_ptr_s, rd_ptr_s;
  logic                  push_s, pop_s, load_s, out_valid_s;
  logic [ADDR_WIDTH+1:0] level_s;

  // Next pointers and total occupancy (unread entries plus the output register)
  always_comb begin
    push_s      = in_valid & in_ready;
    pop_s       = out_valid & out_ready;
    load_s      = (wr_vis_r != rd_ptr_r) && (!out_valid || pop_s);
    wr_ptr_s    = wr_ptr_r + {{ADDR_WIDTH{1'b0}}, push_s};
    rd_ptr_s    = rd_ptr_r + {{ADDR_WIDTH{1'b0}}, load_s};
    out_valid_s = load_s | (out_valid & ~pop_s);
    level_s     = {1'b0, wr_ptr_s - rd_ptr_s} + {{(ADDR_WIDTH + 1){1'b0}}, out_valid_s};
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[ADDR_WIDTH-1:0]] <= in_data;
    end
  end

  // Pointers, output register and registered ready
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      wr_ptr_r  <= '0;
      wr_vis_r  <= '0;
      rd_ptr_r  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      in_ready  <= 1'b0;
    end else begin
      wr_ptr_r  <= wr_ptr_s;
      wr_vis_r  <= wr_ptr_r;
      rd_ptr_r  <= rd_ptr_s;
      out_valid <= out_valid_s;
      in_ready  <= (level_s < DEPTH_LVL);
      if (load_s) begin
        out_data <= mem_r[rd_ptr_r[ADDR_WIDTH-1:0]];
      end
    end
  end

endmodule

// File: rtl/rmt_wrapper.sv
// Stream classifier: tags every beat of a packet with the CLASS and VID taken
// from its first beat, then buffers the beats in a 16-entry FIFO.
module rmt_wrapper
  import rmt_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH   = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH   = 12,
  parameter logic [31:0] C_BASEADDR           = 32'h8000_0000,
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 512,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 512,
  parameter int unsigned PHV_ADDR_WIDTH       = 4
) (
  input  logic                                 clk,
  input  logic                                 aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
  input  logic                                 s_axis_tvalid,
  input  logic                                 s_axis_tlast,
  output logic                                 s_axis_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
  output logic                                 m_axis_tvalid,
  output logic                                 m_axis_tlast,
  input  logic                                 m_axis_tready
);

  localparam int unsigned DW = C_S_AXIS_DATA_WIDTH;
  localparam int unsigned KW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int unsigned UW = C_S_AXIS_TUSER_WIDTH;
  localparam int unsigned FW = DW + KW + 1 + UW;

  if (C_M_AXIS_DATA_WIDTH != C_S_AXIS_DATA_WIDTH || C_S_AXI_DATA_WIDTH == 0 ||
      C_S_AXI_ADDR_WIDTH == 0 || C_BASEADDR[1:0] != 2'b00) begin : g_param_check
    $error("rmt_wrapper: inconsistent parameters");
  end

  logic                 first_r;
  class_e               class_r;
  logic [VID_WIDTH-1:0] vid_r;
  class_e               hdr_class_s, beat_class_s;
  logic [VID_WIDTH-1:0] hdr_vid_s, beat_vid_s;
  logic [UW-1:0]        tuser_s;
  logic                 accept_s;
  logic [FW-1:0]        fifo_in_s, fifo_out_s;

  // Header field extraction and per-beat tag selection
  always_comb begin
    accept_s    = s_axis_tvalid & s_axis_tready;
    hdr_class_s = classify({s_axis_tdata[8*ETYPE_BYTE +: 8], s_axis_tdata[8*(ETYPE_BYTE+1) +: 8]},
                           s_axis_tdata[8*PROTO_BYTE +: 8]);
    hdr_vid_s   = {s_axis_tdata[8*VID_BYTE +: 4], s_axis_tdata[8*(VID_BYTE+1) +: 8]};
    if (first_r) begin
      beat_class_s = hdr_class_s;
      beat_vid_s   = hdr_vid_s;
    end else begin
      beat_class_s = class_r;
      beat_vid_s   = vid_r;
    end
    tuser_s = s_axis_tuser;
    tuser_s[UW-1:TUSER_PAD_LSB]        = '0;
    tuser_s[TUSER_CLASS_LSB +: 2]      = beat_class_s;
    tuser_s[TUSER_VID_LSB +: VID_WIDTH] = beat_vid_s;
    fifo_in_s = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, tuser_s};
  end

  // First-beat tracker and per-packet tag latch
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      first_r <= 1'b1;
      class_r <= CLASS_NON_IP;
      vid_r   <= '0;
    end else if (accept_s) begin
      first_r <= s_axis_tlast;
      class_r <= beat_class_s;
      vid_r   <= beat_vid_s;
    end
  end

  rmt_axis_fifo #(
    .WIDTH      (FW),
    .ADDR_WIDTH (PHV_ADDR_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .aresetn   (aresetn),
    .in_data   (fifo_in_s),
    .in_valid  (s_axis_tvalid),
    .in_ready  (s_axis_tready),
    .out_data  (fifo_out_s),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready)
  );

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} = fifo_out_s;

endmodule

// File: tb/tb_rmt_wrapper.sv
// Scoreboard bench for rmt_wrapper: a reference model tags each accepted beat,
// and the output monitor pops and compares every transferred beat.
module tb_rmt_wrapper;

  typedef struct {
    logic [511:0] d;
    logic [63:0]  k;
    logic         l;
    logic [127:0] u;
  } beat_t;

  logic         clk = 1'b0;
  logic         aresetn;
  logic [511:0] s_axis_tdata;
  logic [63:0]  s_axis_tkeep;
  logic [127:0] s_axis_tuser;
  logic         s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [511:0] m_axis_tdata;
  logic [63:0]  m_axis_tkeep;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid, m_axis_tlast, m_axis_tready;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  beat_t        sb_q[$];
  logic         mdl_first;
  logic [1:0]   mdl_class;
  logic [11:0]  mdl_vid;
  logic         stall_prev = 1'b0;
  logic [704:0] held;

  rmt_wrapper dut (
    .clk(clk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [719:0] act, input logic [719:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [511:0] mk_hdr(input logic [11:0] vid, input logic [15:0] etype,
                                          input logic [7:0] proto);
    logic [511:0] r;
    r = rand512();
    r[8*14 +: 4] = vid[11:8];
    r[8*15 +: 8] = vid[7:0];
    r[8*16 +: 8] = etype[15:8];
    r[8*17 +: 8] = etype[7:0];
    r[8*27 +: 8] = proto;
    return r;
  endfunction

  // Reference classification straight from the header byte layout
  function automatic logic [1:0] ref_class(input logic [511:0] d);
    logic [15:0] et;
    logic [7:0]  pr;
    et = {d[8*16 +: 8], d[8*17 +: 8]};
    pr = d[8*27 +: 8];
    if (et != 16'h0800) return 2'd0;
    if (pr == 8'd6)     return 2'd2;
    if (pr == 8'd17)    return 2'd3;
    return 2'd1;
  endfunction

  task automatic model_push(input logic [511:0] d, input logic [63:0] k, input logic l,
                            input logic [127:0] u);
    beat_t b;
    if (mdl_first) begin
      mdl_class = ref_class(d);
      mdl_vid   = {d[8*14 +: 4], d[8*15 +: 8]};
    end
    b.d = d; b.k = k; b.l = l;
    b.u = {2'b00, mdl_class, mdl_vid, u[111:0]};
    sb_q.push_back(b);
    mdl_first = l;
  endtask

  task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic l,
                           input logic [127:0] u);
    bit acc = 1'b0;
    int n = 0;
    s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tuser = u;
    s_axis_tvalid = 1'b1;
    while (!acc && n < 64) begin
      @(negedge clk);
      acc = s_axis_tready;
      @(posedge clk); #1;
      n++;
    end
    if (acc) model_push(d, k, l, u);
    else begin
      chk("send_timeout", 720'd0, 720'd1);
      s_axis_tvalid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    s_axis_tvalid = 1'b0;
    while (sb_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_left", 720'(sb_q.size()), 720'd0);
  endtask

  task automatic do_reset(input int cycles);
    s_axis_tvalid = 1'b0;
    aresetn = 1'b0;
    repeat (cycles) begin @(posedge clk); #1; end
    sb_q.delete();
    mdl_first = 1'b1;
    aresetn = 1'b1;
  endtask

  // Output monitor: scoreboard compare on transfer, stability check while stalled
  always @(negedge clk) begin
    if (!aresetn) begin
      stall_prev = 1'b0;
    end else if (m_axis_tvalid) begin
      if (stall_prev)
        chk("stall_stable", 720'({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}), 720'(held));
      if (m_axis_tready) begin
        stall_prev = 1'b0;
        if (sb_q.size() == 0) chk("unexpected_beat", 720'd1, 720'd0);
        else begin
          beat_t e;
          e = sb_q.pop_front();
          chk("tdata", 720'(m_axis_tdata), 720'(e.d));
          chk("tkeep", 720'(m_axis_tkeep), 720'(e.k));
          chk("tlast", 720'(m_axis_tlast), 720'(e.l));
          chk("tuser", 720'(m_axis_tuser), 720'(e.u));
        end
      end else begin
        stall_prev = 1'b1;
        held = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
      end
    end else begin
      if (stall_prev) chk("valid_dropped", 720'd0, 720'd1);
      stall_prev = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [511:0] h;
    logic [511:0] bp_d [20];
    logic [127:0] bp_u [20];
    int t0, acc_cnt;
    bit a;

    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = '0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
    mdl_first = 1'b1; mdl_class = 2'd0; mdl_vid = 12'd0;

    // Reset state
    aresetn = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("rst_tvalid", 720'(m_axis_tvalid), 720'd0);
    chk("rst_tlast",  720'(m_axis_tlast),  720'd0);
    chk("rst_tdata",  720'(m_axis_tdata),  720'd0);
    chk("rst_tkeep",  720'(m_axis_tkeep),  720'd0);
    chk("rst_tuser",  720'(m_axis_tuser),  720'd0);
    chk("rst_tready", 720'(s_axis_tready), 720'd0);
    aresetn = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("tready_after_rst", 720'(s_axis_tready), 720'd1);

    // One-cycle reset pulse
    @(posedge clk); #1;
    do_reset(1);
    @(negedge clk);
    chk("pulse_tready_low", 720'(s_axis_tready), 720'd0);
    chk("pulse_tvalid_low", 720'(m_axis_tvalid), 720'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("pulse_tready_high", 720'(s_axis_tready), 720'd1);
    @(posedge clk); #1;

    // Non-IP 4-beat packet, back to back
    h = {{16{8'hff}}, 256'b0, 12'h020, 116'b0};
    t0 = cyc;
    send_beat(h, '1, 1'b0, rand128());
    for (int i = 1; i < 4; i++) send_beat(rand512(), '1, (i == 3), rand128());
    chk("throughput_cycles", 720'(cyc - t0), 720'd4);
    drain();

    // IPv4/UDP after 6 idle cycles with latency check
    repeat (6) begin @(posedge clk); #1; end
    h = {1'b0, {16{8'hff}}, 159'b0, 8'h11, 72'b0, 16'h0008, 128'b0};
    send_beat(h, '1, 1'b0, rand128());
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("latency_n1_tvalid", 720'(m_axis_tvalid), 720'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("latency_n2_tvalid", 720'(m_axis_tvalid), 720'd1);
    chk("latency_n2_class", 720'(m_axis_tuser[125:124]), 720'd3);
    @(posedge clk); #1;
    for (int i = 1; i < 4; i++) send_beat(rand512(), '1, (i == 3), rand128());
    drain();

    // TCP then IPv4-other single-beat packet
    send_beat(mk_hdr(12'h9ab, 16'h0800, 8'd6), '1, 1'b0, rand128());
    send_beat(rand512(), 64'h0000_0000_0000_ffff, 1'b1, rand128());
    send_beat(mk_hdr(12'h321, 16'h0800, 8'd1), 64'h0fff_ffff_ffff_ffff, 1'b1, rand128());
    send_beat(mk_hdr(12'hfff, 16'h86dd, 8'd17), '1, 1'b1, rand128());
    drain();

    // Backpressure: 20 offered beats, 16 fit while output is stalled
    bp_d[0] = mk_hdr(12'h5a5, 16'h0800, 8'd6);
    bp_u[0] = rand128();
    for (int i = 1; i < 20; i++) begin bp_d[i] = rand512(); bp_u[i] = rand128(); end
    m_axis_tready = 1'b0;
    acc_cnt = 0;
    s_axis_tdata = bp_d[0]; s_axis_tkeep = '1; s_axis_tlast = 1'b0; s_axis_tuser = bp_u[0];
    s_axis_tvalid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      a = s_axis_tready;
      @(posedge clk); #1;
      if (a && s_axis_tvalid) begin
        model_push(bp_d[acc_cnt], '1, (acc_cnt == 19), bp_u[acc_cnt]);
        acc_cnt++;
        s_axis_tdata = bp_d[acc_cnt % 20]; s_axis_tuser = bp_u[acc_cnt % 20];
        s_axis_tlast = (acc_cnt == 19);
      end
    end
    chk("bp_accepted", 720'(acc_cnt), 720'd16);
    @(negedge clk);
    chk("bp_tready_low", 720'(s_axis_tready), 720'd0);
    @(posedge clk); #1;
    m_axis_tready = 1'b1;
    for (int c = 0; c < 60 && acc_cnt < 20; c++) begin
      @(negedge clk);
      a = s_axis_tready;
      @(posedge clk); #1;
      if (a) begin
        model_push(bp_d[acc_cnt], '1, (acc_cnt == 19), bp_u[acc_cnt]);
        acc_cnt++;
        if (acc_cnt < 20) begin
          s_axis_tdata = bp_d[acc_cnt]; s_axis_tuser = bp_u[acc_cnt];
          s_axis_tlast = (acc_cnt == 19);
        end else s_axis_tvalid = 1'b0;
      end
    end
    chk("bp_total", 720'(acc_cnt), 720'd20);
    drain();

    // Mid-packet reset discards buffered beats
    m_axis_tready = 1'b0;
    send_beat(mk_hdr(12'h0aa, 16'h0800, 8'd6), '1, 1'b0, rand128());
    send_beat(rand512(), '1, 1'b0, rand128());
    s_axis_tvalid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    do_reset(1);
    @(negedge clk);
    chk("midrst_tvalid", 720'(m_axis_tvalid), 720'd0);
    @(posedge clk); #1;
    m_axis_tready = 1'b1;
    send_beat(mk_hdr(12'h123, 16'h0800, 8'd17), '1, 1'b0, rand128());
    send_beat(rand512(), 64'h0000_0000_ffff_ffff, 1'b1, rand128());
    drain();
    repeat (5) begin @(posedge clk); #1; end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
